// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 transmit arbiter.
package rs232_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RELEASE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TO_CYCLES = 1048576;

endpackage

// File: rtl/rs232_tx_arb_if.sv
// Requester and transmitter signal bundle for rs232_tx_arb.
interface rs232_tx_arb_if;

    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       busy;
    logic       grant;
    logic       timeout_err;

    modport master (
        output req0, data0, req1, data1, tx_ack,
        input  ack0, ack1, tx_req, tx_data, busy, grant, timeout_err
    );

    modport slave (
        input  req0, data0, req1, data1, tx_ack,
        output ack0, ack1, tx_req, tx_data, busy, grant, timeout_err
    );

endinterface

// File: rtl/rs232_rr_pick.sv
// Two-way round-robin pick between requesters 0 and 1.
module rs232_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    // A tie goes to whichever side did not win last time.
    assign winner = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/rs232_tx_arb.sv
// Shares one UART transmitter between two byte requesters, with a per-byte watchdog.
module rs232_tx_arb
    import rs232_pkg::*;
#(
    parameter int unsigned TO_CYCLES = DEFAULT_TO_CYCLES
) (
    input logic           clk,
    input logic           rst,
    rs232_tx_arb_if.slave bus
);

    localparam int unsigned     WD_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYCLES - 1);

    state_e          state_q, state_d;
    logic            tx_req_q, tx_req_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            timeout_q, timeout_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic pick_valid;
    logic pick_winner;

    rs232_rr_pick u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_req_q     <= 1'b0;
            tx_data_q    <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            timeout_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            timeout_q    <= timeout_d;
            wd_q         <= wd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_req_d     = tx_req_q;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        timeout_d    = 1'b0;
        wd_d         = wd_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    tx_data_d    = pick_winner ? bus.data1 : bus.data0;
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    tx_req_d     = 1'b1;
                    wd_d         = '0;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // tx_ack takes priority, so a coincident limit is a normal completion.
                if (bus.tx_ack || (wd_q == WD_LAST)) begin
                    tx_req_d  = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    timeout_d = ~bus.tx_ack;
                    state_d   = RELEASE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_req      = tx_req_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant       = grant_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.timeout_err = timeout_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Self-checking bench for rs232_tx_arb: vector table, random transfers against a transaction model, reset abort.
module tb_rs232_tx_arb;

    localparam int unsigned TO = 16;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int unsigned ack_k;
        bit          scr;
        logic        exp_w;
        logic [7:0]  exp_d;
        logic        exp_to;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic m_last;

    rs232_tx_arb_if bus ();

    rs232_tx_arb #(.TO_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic xfer(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1,
                        input int unsigned ack_k, input bit scr,
                        input logic exp_w, input logic [7:0] exp_d, input logic exp_to);
        bus.req0  = r0;
        bus.req1  = r1;
        bus.data0 = d0;
        bus.data1 = d1;
        @(negedge clk);
        if (!(r0 || r1)) begin
            chk("idle_no_req", 32'({bus.busy, bus.tx_req, bus.ack1, bus.ack0}), 32'h0);
            return;
        end
        chk("grant_tx", 32'({bus.tx_req, bus.busy, bus.grant, bus.tx_data}),
            32'({1'b1, 1'b1, exp_w, exp_d}));
        for (int unsigned k = 0; k < TO; k++) begin
            if (scr) begin
                bus.data0 = 8'hFF;
                bus.data1 = 8'($urandom);
            end
            bus.tx_ack = (k == ack_k);
            @(negedge clk);
            bus.tx_ack = 1'b0;
            if (k == ack_k || k == TO - 1) break;
            chk("wait_hold", 32'({bus.tx_req, bus.grant, bus.tx_data, bus.ack1, bus.ack0, bus.timeout_err}),
                32'({1'b1, exp_w, exp_d, 2'b00, 1'b0}));
        end
        chk("release", 32'({bus.tx_req, bus.busy, bus.ack1, bus.ack0, bus.timeout_err}),
            32'({1'b0, 1'b1, exp_w, ~exp_w, exp_to}));
        bus.tx_ack = scr;
        @(negedge clk);
        bus.tx_ack = 1'b0;
        chk("back_idle", 32'({bus.busy, bus.tx_req, bus.ack1, bus.ack0, bus.timeout_err}), 32'h0);
    endtask

    initial begin
        vec_t        vecs [11];
        logic        r0, r1, ew;
        logic [7:0]  d0, d1;
        int unsigned ak;
        bit          sc;

        n_chk  = 0;
        n_fail = 0;
        vecs[0]  = '{1'b1, 1'b1, 8'h11, 8'h22, 3,  1'b0, 1'b0, 8'h11, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'h11, 8'h22, 5,  1'b0, 1'b1, 8'h22, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h11, 8'h22, 0,  1'b0, 1'b0, 8'h11, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'h11, 8'h22, 7,  1'b1, 1'b1, 8'h22, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 9,  1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h3C, 8'h00, 2,  1'b1, 1'b0, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 15, 1'b0, 1'b1, 8'h5A, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h77, 20, 1'b0, 1'b1, 8'h77, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 0,  1'b0, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h01, 8'h02, 99, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 8'h01, 8'h02, 1,  1'b0, 1'b1, 8'h02, 1'b0};

        rst        = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.data0  = '0;
        bus.data1  = '0;
        bus.tx_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({bus.busy, bus.tx_req, bus.tx_data, bus.grant, bus.ack1, bus.ack0, bus.timeout_err}), 32'h0);
        rst = 1'b0;

        // tx_ack in IDLE must be ignored
        bus.tx_ack = 1'b1;
        @(negedge clk);
        bus.tx_ack = 1'b0;
        chk("idle_txack", 32'({bus.busy, bus.tx_req, bus.ack1, bus.ack0, bus.timeout_err}), 32'h0);

        m_last = 1'b1;
        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].ack_k, vecs[i].scr,
                 vecs[i].exp_w, vecs[i].exp_d, vecs[i].exp_to);
            if (vecs[i].r0 || vecs[i].r1) m_last = vecs[i].exp_w;
        end

        // Random transfers against a round-robin transaction model
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            ak = $urandom_range(0, 19);
            sc = 1'($urandom_range(0, 1));
            ew = (r0 && r1) ? ~m_last : r1;
            xfer(r0, r1, d0, d1, ak, sc, ew, ew ? d1 : d0, ak >= TO);
            if (r0 || r1) m_last = ew;
        end

        // Reset in the middle of a requester-0 transfer
        bus.req0  = 1'b1;
        bus.req1  = 1'b0;
        bus.data0 = 8'hC3;
        @(negedge clk);
        chk("abort_grant", 32'({bus.tx_req, bus.grant, bus.tx_data}), 32'({1'b1, 1'b0, 8'hC3}));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_async", 32'({bus.busy, bus.tx_req, bus.tx_data, bus.grant, bus.ack1, bus.ack0, bus.timeout_err}), 32'h0);
        bus.req1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_noack", 32'({bus.busy, bus.ack1, bus.ack0, bus.timeout_err}), 32'h0);
        end
        rst = 1'b0;
        xfer(1'b1, 1'b1, 8'h44, 8'h88, 4, 1'b0, 1'b0, 8'h44, 1'b0);
        xfer(1'b1, 1'b1, 8'h44, 8'h88, 4, 1'b0, 1'b1, 8'h88, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arb.md
RS232_TX_ARB -- requirements
Module: rs232_tx_arb

Interface
REQ-001 Parameter TO_CYCLES, default 1048576, SHALL set the watchdog limit in clk cycles for one byte transfer.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 req0  input  1  SHALL be requester 0's level request; data0 is valid while it is high.
REQ-005 data0  input  8  SHALL be requester 0's byte.
REQ-006 ack0  output  1  SHALL be a one-cycle pulse: requester 0's byte is finished.
REQ-007 req1 / data1 / ack1  SHALL be the same as req0 / data0 / ack0, for requester 1.
REQ-008 tx_req  output  1  SHALL be the level request to the UART transmitter.
REQ-009 tx_data  output  8  SHALL be the byte presented to the transmitter.
REQ-010 tx_ack  input  1  SHALL be the transmitter's one-cycle completion pulse (stop bit done).
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-012 grant  output  1  SHALL be the index of the requester currently owning the transmitter.
REQ-013 timeout_err  output  1  SHALL be a one-cycle pulse: watchdog expired.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, WAIT_ACK, RELEASE.
REQ-015 In IDLE with any reqN high, the next edge SHALL:
  - latch the winner's data into tx_data;
  - set grant;
  - assert tx_req;
  - clear the watchdog;
  - enter WAIT_ACK.
  Latency from request to tx_req is 1 cycle.
REQ-016 Arbitration SHALL be round-robin.
  - With both requests high, the requester not equal to last_grant wins.
  - With one request high, that requester wins regardless of last_grant.
REQ-017 last_grant SHALL update only on a grant.
REQ-018 In WAIT_ACK:
  - tx_req SHALL stay high;
  - tx_data and grant SHALL stay constant, independent of reqN/dataN changes;
  - the watchdog SHALL increment each cycle.
REQ-019 In WAIT_ACK, tx_ack=1 SHALL cause, at the next edge: tx_req=0, ack[grant]=1, state=RELEASE.
REQ-020 In WAIT_ACK, watchdog = TO_CYCLES-1 with tx_ack=0 SHALL cause, at the next edge: tx_req=0, ack[grant]=1, timeout_err=1, state=RELEASE.
REQ-021 tx_ack and the watchdog limit occurring in the same cycle SHALL count as normal completion (no timeout_err).
REQ-022 RELEASE SHALL last exactly one cycle, ignore all requests, then return to IDLE.
  - The ackN pulse and the timeout_err pulse coincide with RELEASE.
  - Requesters update or drop req/data at the edge ending RELEASE.
REQ-023 tx_ack arriving in IDLE or RELEASE SHALL be ignored.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle; at most one ack occurs per grant.
REQ-025 A requester holding req high continuously SHALL be re-granted no earlier than the IDLE cycle after RELEASE, subject to round-robin.
REQ-026 The watchdog counter SHALL be $clog2(TO_CYCLES) bits wide, SHALL saturate (never wrap), and SHALL be cleared on every grant.

Reset
REQ-027 While rst=1, all of the following SHALL hold asynchronously: state=IDLE, tx_req=0, tx_data=8'h00, grant=0, last_grant=1, ack0=ack1=0, timeout_err=0, busy=0, watchdog=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no ack or timeout_err pulse.
REQ-029 The first grant after reset SHALL go to requester 0 on a tie.

Structure
REQ-030 The state enum (IDLE, WAIT_ACK, RELEASE) and the constant DEFAULT_TO_CYCLES SHALL live in shared package rs232_pkg.
REQ-031 The round-robin pick SHALL be a combinational sub-module named rs232_rr_pick.
  - Inputs: req0, req1, last_grant.
  - Outputs: valid, winner.
REQ-032 All other logic SHALL be flat inside rs232_tx_arb.

Verification
REQ-033 Single request:
  - Stimulus: req0=1, data0=8'hA5; tx_ack pulsed 10 cycles later.
  - Response: tx_req=1 with tx_data=8'hA5 one cycle after req0; ack0 pulse in the cycle after tx_ack; tx_req low.
REQ-034 Tie after reset:
  - Stimulus: req0 and req1 rise together, data0=8'h11, data1=8'h22, both held.
  - Response: bytes sent in order 11, 22, 11, 22; ack0/ack1 alternate.
REQ-035 Data hold:
  - Stimulus: data0 changes to 8'hFF while in WAIT_ACK.
  - Response: tx_data remains the latched value until RELEASE.
REQ-036 Timeout:
  - Stimulus: TO_CYCLES=16; no tx_ack.
  - Response: timeout_err and ack[grant] pulse 16 cycles after tx_req rose; FSM returns to IDLE.
REQ-037 Simultaneous completion:
  - Stimulus: tx_ack at watchdog=TO_CYCLES-1.
  - Response: ack pulse, timeout_err=0.
REQ-038 Reset mid-transfer:
  - Stimulus: rst pulsed in WAIT_ACK.
  - Response: outputs reach reset values immediately; no ack; next tie is granted to requester 0.
